// File: rtl/kmeans_sample_buffer.sv
// kmeans_sample_buffer
// Collects one frame of SAMPS x DIMS words from a valid/ready stream into a
// register array, signals the k-means core with a one-cycle start pulse, and
// serves a combinational read port until the core releases the frame.
module kmeans_sample_buffer #(
    parameter int DIMS  = 6,
    parameter int SAMPS = 128,
    parameter int W     = 16,
    parameter int AW    = $clog2(SAMPS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [W-1:0]           s_data_i,
    input  logic                   s_first_i,
    input  logic [AW-1:0]          rd_addr_i,
    output logic [DIMS-1:0][W-1:0] rd_data_o,
    output logic                   start_o,
    input  logic                   release_i,
    output logic                   sync_err_o,
    output logic [7:0]             frame_cnt_o
);

    localparam int DW = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam logic [DW-1:0] DIM_LAST  = DW'(DIMS - 1);
    localparam logic [AW-1:0] SAMP_LAST = AW'(SAMPS - 1);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t         state_r, state_next_s;
    logic [DW-1:0]  dim_r, dim_next_s;
    logic [AW-1:0]  samp_r, samp_next_s;
    logic [7:0]     frame_r, frame_next_s;
    logic           ready_r;
    logic           start_r, start_next_s;
    logic           sync_err_r, sync_err_next_s;
    logic           beat_s;
    logic           we_s;
    logic [AW-1:0]  wr_samp_s;
    logic [DW-1:0]  wr_dim_s;

    logic [W-1:0]   mem_r [SAMPS][DIMS];

    // Ready is registered from the next state, so it never depends on s_valid_i.
    assign beat_s      = s_valid_i && ready_r;
    assign s_ready_o   = ready_r;
    assign start_o     = start_r;
    assign sync_err_o  = sync_err_r;
    assign frame_cnt_o = frame_r;

    // Next-state, counter advance and write-address decode.
    always_comb begin
        state_next_s    = state_r;
        dim_next_s      = dim_r;
        samp_next_s     = samp_r;
        frame_next_s    = frame_r;
        start_next_s    = 1'b0;
        sync_err_next_s = 1'b0;
        we_s            = 1'b0;
        wr_samp_s       = samp_r;
        wr_dim_s        = dim_r;
        case (state_r)
            WAIT_SOF: begin
                if (beat_s && s_first_i) begin
                    we_s         = 1'b1;
                    wr_samp_s    = '0;
                    wr_dim_s     = '0;
                    dim_next_s   = DW'(1);
                    samp_next_s  = '0;
                    state_next_s = FILL;
                end else begin
                    state_next_s = WAIT_SOF;
                end
            end
            FILL: begin
                if (beat_s && s_first_i) begin
                    // Restart: the partial frame is abandoned, word 0 rewritten.
                    we_s            = 1'b1;
                    wr_samp_s       = '0;
                    wr_dim_s        = '0;
                    dim_next_s      = DW'(1);
                    samp_next_s     = '0;
                    sync_err_next_s = 1'b1;
                end else if (beat_s) begin
                    we_s = 1'b1;
                    if (dim_r == DIM_LAST) begin
                        dim_next_s = '0;
                        if (samp_r == SAMP_LAST) begin
                            samp_next_s  = '0;
                            frame_next_s = frame_r + 8'd1;
                            start_next_s = 1'b1;
                            state_next_s = HOLD;
                        end else begin
                            samp_next_s = samp_r + AW'(1);
                        end
                    end else begin
                        dim_next_s = dim_r + DW'(1);
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            HOLD: begin
                if (release_i) begin
                    state_next_s = WAIT_SOF;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = WAIT_SOF;
                dim_next_s   = '0;
                samp_next_s  = '0;
            end
        endcase
    end

    // Control state, counters and registered pulse outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= WAIT_SOF;
            dim_r      <= '0;
            samp_r     <= '0;
            frame_r    <= 8'd0;
            ready_r    <= 1'b1;
            start_r    <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            dim_r      <= dim_next_s;
            samp_r     <= samp_next_s;
            frame_r    <= frame_next_s;
            ready_r    <= (state_next_s != HOLD);
            start_r    <= start_next_s;
            sync_err_r <= sync_err_next_s;
        end
    end

    // Sample array; intentionally not reset, contents valid after a full frame.
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            mem_r[wr_samp_s][wr_dim_s] <= s_data_i;
        end
    end

    // Combinational read of all dimensions of the addressed sample.
    always_comb begin
        rd_data_o = '0;
        for (int d = 0; d < DIMS; d++) begin
            rd_data_o[d] = mem_r[rd_addr_i][d];
        end
    end

endmodule

// File: tb/tb_kmeans_sample_buffer.sv
// Directed self-checking bench for kmeans_sample_buffer: a default-size
// instance for the frame tests and a 2x2 instance for frame counter wrap.
module tb_kmeans_sample_buffer;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [15:0]       s_data_i = 16'd0;
    logic              s_first_i = 1'b0;
    logic [6:0]        rd_addr_i = 7'd0;
    logic [5:0][15:0]  rd_data_o;
    logic              start_o;
    logic              release_i = 1'b0;
    logic              sync_err_o;
    logic [7:0]        frame_cnt_o;

    logic              sm_valid = 1'b0;
    logic              sm_ready;
    logic [15:0]       sm_data = 16'd0;
    logic              sm_first = 1'b0;
    logic [0:0]        sm_addr = 1'b0;
    logic [1:0][15:0]  sm_rd;
    logic              sm_start;
    logic              sm_release = 1'b0;
    logic              sm_sync;
    logic [7:0]        sm_cnt;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    int sync_cnt = 0;

    kmeans_sample_buffer u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_data_i(s_data_i), .s_first_i(s_first_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .start_o(start_o), .release_i(release_i),
        .sync_err_o(sync_err_o), .frame_cnt_o(frame_cnt_o)
    );

    kmeans_sample_buffer #(.DIMS(2), .SAMPS(2), .W(16)) u_small (
        .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(sm_valid), .s_ready_o(sm_ready),
        .s_data_i(sm_data), .s_first_i(sm_first), .rd_addr_i(sm_addr),
        .rd_data_o(sm_rd), .start_o(sm_start), .release_i(sm_release),
        .sync_err_o(sm_sync), .frame_cnt_o(sm_cnt)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk_i) begin
        if (start_o)    start_cnt++;
        if (sync_err_o) sync_cnt++;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [15:0] pat(input logic [15:0] base, input int s, input int d);
        logic [15:0] v;
        v = 16'(s * 16 + d);
        return base ^ v;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    // One accepted beat on the main stream.
    task automatic push(input logic [15:0] d, input logic f);
        int g;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_first_i = f;
        g = 0;
        while (!s_ready_o && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) chk("push_timeout", 32'd0, 32'd1);
        tick();
        s_valid_i = 1'b0;
        s_first_i = 1'b0;
    endtask

    // Full frame; rs >= 0 replaces beat rs by a 0xBEEF restart word.
    task automatic run_frame(input logic [15:0] base, input bit gaps, input int rs);
        int st0;
        int r;
        st0 = start_cnt;
        r = rs;
        for (int i = 0; i < 768; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) tick();
            if (i == r) begin
                push(16'hBEEF, 1'b1);
                r = -1;
                i = 0;
                continue;
            end
            push(pat(base, i / 6, i % 6), (i == 0));
        end
        chk("start_hi", {31'd0, start_o}, 32'd1);
        chk("start_early", start_cnt - st0, 32'd0);
        chk("ready_hold", {31'd0, s_ready_o}, 32'd0);
        tick();
        chk("start_once", start_cnt - st0, 32'd1);
        chk("start_lo", {31'd0, start_o}, 32'd0);
    endtask

    task automatic release_buf();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("rel_ready", {31'd0, s_ready_o}, 32'd1);
    endtask

    task automatic chk_sample(input string tag, input int s, input logic [15:0] base);
        rd_addr_i = 7'(s);
        #1;
        for (int d = 0; d < 6; d++) chk(tag, {16'd0, rd_data_o[d]}, {16'd0, pat(base, s, d)});
    endtask

    initial begin
        int sc0;
        int g;

        // 1: reset state, plain frame, read-back of sample 5.
        do_reset();
        chk("rst_ready", {31'd0, s_ready_o}, 32'd1);
        chk("rst_start", {31'd0, start_o}, 32'd0);
        chk("rst_sync", {31'd0, sync_err_o}, 32'd0);
        chk("rst_fcnt", {24'd0, frame_cnt_o}, 32'd0);
        run_frame(16'h0000, 1'b0, -1);
        chk("t1_ready", {31'd0, s_ready_o}, 32'd0);
        chk("t1_fcnt", {24'd0, frame_cnt_o}, 32'd1);
        chk_sample("t1_s5", 5, 16'h0000);
        chk_sample("t1_s127", 127, 16'h0000);
        release_buf();

        // 2: non-first beats before a frame are dropped.
        do_reset();
        for (int i = 0; i < 10; i++) push(16'hA000 + 16'(i), 1'b0);
        run_frame(16'h1000, 1'b0, -1);
        chk_sample("t2_s0", 0, 16'h1000);
        chk_sample("t2_s1", 1, 16'h1000);
        chk("t2_fcnt", {24'd0, frame_cnt_o}, 32'd1);
        release_buf();

        // 3: restart mid-frame at beat 300.
        do_reset();
        sc0 = sync_cnt;
        run_frame(16'h0000, 1'b0, 300);
        chk("t3_sync_once", sync_cnt - sc0, 32'd1);
        rd_addr_i = 7'd0;
        #1;
        chk("t3_beef", {16'd0, rd_data_o[0]}, 32'h0000BEEF);
        chk("t3_fcnt", {24'd0, frame_cnt_o}, 32'd1);
        chk_sample("t3_s50", 50, 16'h0000);

        // 4: HOLD ignores the stream.
        s_valid_i = 1'b1;
        s_data_i  = 16'hDEAD;
        for (int i = 0; i < 50; i++) begin
            s_first_i = i[0];
            tick();
        end
        chk("t4_ready", {31'd0, s_ready_o}, 32'd0);
        s_valid_i = 1'b0;
        s_first_i = 1'b0;
        rd_addr_i = 7'd0;
        #1;
        chk("t4_beef", {16'd0, rd_data_o[0]}, 32'h0000BEEF);
        chk_sample("t4_s5", 5, 16'h0000);
        chk("t4_sync", sync_cnt - sc0, 32'd1);
        chk("t4_fcnt", {24'd0, frame_cnt_o}, 32'd1);
        release_buf();

        // 5: gapped frame gives the full expected image.
        do_reset();
        run_frame(16'h2000, 1'b1, -1);
        for (int s = 0; s < 128; s++) chk_sample("t5_img", s, 16'h2000);
        chk("t5_fcnt", {24'd0, frame_cnt_o}, 32'd1);
        release_buf();

        // 6: asynchronous reset at beat 400.
        for (int i = 0; i < 400; i++) push(pat(16'h0F00, i / 6, i % 6), (i == 0));
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_fcnt_clr", {24'd0, frame_cnt_o}, 32'd0);
        chk("t6_start_clr", {31'd0, start_o}, 32'd0);
        chk("t6_sync_clr", {31'd0, sync_err_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("t6_ready", {31'd0, s_ready_o}, 32'd1);
        for (int i = 0; i < 3; i++) push(16'h5555, 1'b0);
        run_frame(16'h3000, 1'b0, -1);
        chk("t6_fcnt", {24'd0, frame_cnt_o}, 32'd1);
        chk_sample("t6_s0", 0, 16'h3000);
        chk_sample("t6_s127", 127, 16'h3000);
        release_buf();

        // 5b: 256 back-to-back frames on the 2x2 instance wrap the counter.
        do_reset();
        sm_valid   = 1'b1;
        sm_release = 1'b1;
        for (int f = 0; f < 256; f++) begin
            for (int b = 0; b < 4; b++) begin
                sm_first = (b == 0);
                sm_data  = 16'(f * 4 + b);
                g = 0;
                while (!sm_ready && g < 10) begin
                    tick();
                    g++;
                end
                if (g >= 10) chk("sm_timeout", 32'd0, 32'd1);
                tick();
            end
            if (f == 0)   chk("sm_cnt1", {24'd0, sm_cnt}, 32'd1);
            if (f == 254) chk("sm_cnt255", {24'd0, sm_cnt}, 32'd255);
        end
        chk("sm_wrap", {24'd0, sm_cnt}, 32'd0);
        sm_addr = 1'b1;
        #1;
        chk("sm_data", {16'd0, sm_rd[1]}, 32'd1023);
        sm_valid   = 1'b0;
        sm_release = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kmeans_sample_buffer.md
Name: kmeans_sample_buffer

Overview:
Upstream stage of the k-means classifier. It collects one frame of sensor samples from a word-serial valid/ready stream into a SAMPS x DIMS register array. When the frame is complete it pulses start_o to the k-means core. It then serves the core's combinational read port (address in, DIMS words out, same cycle) until release_i frees the buffer for the next frame.

Parameters:
DIMS, 6, dimensions per sample (words per sample)
SAMPS, 128, samples per frame (power of two)
W, 16, bits per dimension word
AW, $clog2(SAMPS), read address width (7 by default)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
s_valid_i  in  1  stream word valid
s_ready_o  out  1  buffer accepts a word this cycle
s_data_i  in  W  stream word; dims arrive in order 0..DIMS-1, samples in order 0..SAMPS-1
s_first_i  in  1  marks word [sample 0][dim 0] of a frame
rd_addr_i  in  AW  sample address from k-means core
rd_data_o  out  DIMS x W  combinational read: mem[rd_addr_i][0..DIMS-1]
start_o  out  1  one-cycle pulse: frame ready
release_i  in  1  core finished with the frame; buffer may refill
sync_err_o  out  1  one-cycle pulse: frame restarted mid-fill
frame_cnt_o  out  8  completed frames, wraps 255->0

Behaviour:
- Beat = s_valid_i && s_ready_o. Only beats change counters or memory.
- Counters: dim_cnt 0..DIMS-1, samp_cnt 0..SAMPS-1. dim_cnt wraps to 0 and samp_cnt increments after dim DIMS-1.
- States: WAIT_SOF, FILL, HOLD.
- WAIT_SOF (reset state): s_ready_o=1.
  - Beat with s_first_i=0 is dropped; no write.
  - Beat with s_first_i=1 writes mem[0][0], sets dim_cnt=1, samp_cnt=0, and goes to FILL.
- FILL: s_ready_o=1.
  - Beat with s_first_i=0 writes mem[samp_cnt][dim_cnt], then counters advance.
  - Beat with s_first_i=1 writes mem[0][0] and sets counters to dim 1 / samp 0. sync_err_o pulses the next cycle; the partial frame is discarded and the state stays FILL.
  - Beat at [SAMPS-1][DIMS-1] with s_first_i=0 writes, clears counters, increments frame_cnt_o, goes to HOLD, and registers start_o=1 for exactly the first HOLD cycle.
- HOLD: s_ready_o=0 and memory is frozen.
  - release_i=1 goes to WAIT_SOF in the next cycle; s_ready_o is 1 from that cycle.
  - release_i in WAIT_SOF or FILL is ignored.
  - release_i in the same cycle as start_o is legal and leaves HOLD after one cycle.
- s_ready_o is a pure function of state (no combinational path from s_valid_i).
- Read port is combinational in every state. Data is guaranteed meaningful only in HOLD; in other states it reflects the partially written array.
- Reset (asynchronous, any state, mid-frame included):
  - state=WAIT_SOF, counters=0.
  - start_o=0, sync_err_o=0, frame_cnt_o=0.
  - s_ready_o=1 after reset deasserts.
  - Memory is not reset; contents are undefined until the first complete frame.
- Latency: the last beat at edge N gives start_o high during cycle N+1.
- Minimum frame time: SAMPS*DIMS beats (768 by default).
- No arithmetic beyond counters. frame_cnt_o is an 8-bit modular increment.

Test Plan:
1. Reset, then 768 beats with s_valid_i=1 and data = samp*16+dim, s_first_i on beat 0 -> start_o pulses once, 1 cycle after beat 767. s_ready_o=0. frame_cnt_o=1. rd_addr_i=5 gives rd_data_o = {80,81,82,83,84,85}.
2. 10 beats with s_first_i=0 after reset, then a full frame -> the 10 beats are dropped. mem[0][0] equals the first s_first_i word. start_o comes after exactly 768 accepted frame beats.
3. Frame with s_first_i re-asserted at beat 300 (new value 0xBEEF) -> sync_err_o pulses once. mem[0][0]=0xBEEF. start_o only after 767 further beats. frame_cnt_o=1.
4. In HOLD, drive s_valid_i=1 for 50 cycles, then release_i -> no writes occur and read data is unchanged. s_ready_o returns high 1 cycle after release_i.
5. Toggle s_valid_i randomly (about 50%) across a frame -> identical memory image and a single start_o. 256 back-to-back frames leave frame_cnt_o=0.
6. Assert rst_i asynchronously at beat 400 -> outputs clear immediately and state is WAIT_SOF. The next full frame completes normally with frame_cnt_o=1.
